divres_reconstructor: RTL and testbench

Sequential inverse of the reduced non-restoring divider datapath. Accepts a quotient, divisor and corrected remainder, then rebuilds the dividend as R_0 = Q*D + R_n1 using shift-add over QW cycles followed by one add cycle. Sits beside the divider benchmarks as a round-trip checker and golden-model source for divider equivalence runs. Uses a valid/ready handshake on both the operand side and the result side.

---
 rtl/divres_reconstructor.sv | 125 ++++++++++++
 tb/tb_divres_reconstructor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/divres_reconstructor.sv
// Rebuilds a divider dividend as R_0 = Q*D + R_n1 by shift-add, then one add.
// Ports: clk, rst_n, in_valid/in_ready + Q/D/R_n1 in, out_valid/out_ready + R_0/ovf/err out. Macro: DIVRES_RANGE_CHECK_EN.
module divres_reconstructor #(
  parameter int QW = 4,
  parameter int DW = 3,
  parameter int RW = 4,
  parameter int NW = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QW-1:0]    Q,
  input  logic [DW-1:0]    D,
  input  logic [RW-1:0]    R_n1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW+DW-1:0] R_0,
  output logic             ovf,
  output logic             err
);

  localparam int PW = QW + DW;
  localparam int SW = ((PW > NW) ? PW : NW) + 1;
  localparam int CW = $clog2(QW + 1);
  localparam logic [SW-1:0] LIM = SW'(1) << NW;
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD,
    DONE
  } state_t;

  state_t        state;
  logic [QW-1:0] q_sh;
  logic [PW-1:0] d_sh;
  logic [PW-1:0] acc;
  logic [RW-1:0] r_hold;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sum;

  // Extra headroom bit so ovf sees the untruncated sum.
  assign sum = SW'(acc) + SW'(r_hold);

  assign in_ready = (state == IDLE);

`ifdef DIVRES_RANGE_CHECK_EN
  logic [DW-1:0] d_hold;
  logic          range_err;

  assign range_err = (d_hold == '0) ||
                     (r_hold >= RW'(d_hold));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_hold <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            d_hold <= D;
            err    <= 1'b0;
          end
        end
        ADD:     err <= range_err;
        default: ;
      endcase
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q_sh      <= '0;
      d_sh      <= '0;
      acc       <= '0;
      r_hold    <= '0;
      cnt       <= '0;
      R_0       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            q_sh   <= Q;
            d_sh   <= PW'(D);
            r_hold <= R_n1;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          if (q_sh[0]) acc <= acc + d_sh;
          d_sh <= d_sh << 1;
          q_sh <= q_sh >> 1;
          cnt  <= cnt + 1'b1;
          // Fixed latency: always QW steps, no early exit.
          if (cnt == LAST) state <= ADD;
        end
        ADD: begin
          R_0       <= sum[PW-1:0];
          ovf       <= (sum >= LIM);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divres_reconstructor.sv
// Scoreboarded directed and round-trip bench for divres_reconstructor.
// Expected R_0/ovf/err come from a bench-side product model and the original dividend.
module tb_divres_reconstructor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] q_i;
  logic [2:0] d_i;
  logic [3:0] r_i;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] r0_o;
  logic       ovf_o;
  logic       err_o;

  typedef struct {
    logic [6:0] r0;
    logic       ovf;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   vecs;
  int   errs;

  divres_reconstructor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Q        (q_i),
    .D        (d_i),
    .R_n1     (r_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .R_0      (r0_o),
    .ovf      (ovf_o),
    .err      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready_wait"}, int'(in_ready), 1);
  endtask

  task automatic run_op(input string tag, input int q, input int d,
                        input int r, input int exp_r0, input bit hold);
    exp_t e;
    exp_t got;
    int   lat;
    logic [6:0] r0_snap;
    wait_ready(tag);
    e.r0  = 7'(exp_r0);
    e.ovf = (exp_r0 >= 64);
`ifdef DIVRES_RANGE_CHECK_EN
    e.err = (d == 0) || (r >= d);
`else
    e.err = 1'b0;
`endif
    q_i = 4'(q);
    d_i = 3'(d);
    r_i = 4'(r);
    in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_in_ready_drop"}, int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    if (out_valid && sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, "_R_0"}, int'(r0_o), int'(got.r0));
      chk({tag, "_ovf"}, int'(ovf_o), int'(got.ovf));
      chk({tag, "_err"}, int'(err_o), int'(got.err));
    end else begin
      chk({tag, "_result_present"}, 0, 1);
    end
    if (hold) begin
      r0_snap = r0_o;
      for (int i = 0; i < 10; i++) begin
        if (i == 3) begin
          q_i = 4'd1;
          d_i = 3'd1;
          r_i = 4'd1;
          in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_hold_valid"}, int'(out_valid), 1);
        chk({tag, "_hold_R_0"}, int'(r0_o), int'(r0_snap));
        chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, int'(out_valid), 0);
    chk({tag, "_in_ready_back"}, int'(in_ready), 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    vecs      = 0;
    errs      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q_i = '0;
    d_i = '0;
    r_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_R_0", int'(r0_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    chk("rst_err", int'(err_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic", 5, 3, 2, 17, 1'b0);
    run_op("max", 15, 7, 6, 111, 1'b0);
    run_op("dzero", 9, 0, 3, 3, 1'b0);
    run_op("bp", 2, 5, 4, 14, 1'b1);

    // Reset in the middle of MUL; R_0 still holds 14 going in.
    wait_ready("midrst");
    q_i = 4'd6;
    d_i = 3'd6;
    r_i = 4'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_R_0", int'(r0_o), 0);
    chk("midrst_ovf", int'(ovf_o), 0);
    chk("midrst_err", int'(err_o), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", int'(in_ready), 1);
    run_op("post_rst", 1, 1, 0, 1, 1'b0);

    // Round trip: divide every dividend, rebuild, expect the original back.
    for (int n = 0; n < 64; n++) begin
      for (int d = 1; d < 8; d++) begin
        if (n / d < 16)
          run_op("roundtrip", n / d, d, n % d, n, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
